lift_call_panel: RTL

- Request-side front end for the `lift` controller.
- Synchronizes and debounces raw hall-call and car-call buttons, and merges them into one pending-request vector `floor_req` that drives the controller.
- Watches the controller's `motor_signal` and car position, and clears a floor's request when the car stops there.
- Runs the door-open dwell and reports each serviced floor.

---
 rtl/lift_pkg.sv | 11 +
 rtl/lift_btn_debounce.sv | 47 ++++
 rtl/lift_call_panel.sv | 103 ++++++++++
 3 files changed

// File: rtl/lift_pkg.sv
// rtl/lift_pkg.sv - shared constants and types for the lift call panel
package lift_pkg;
  localparam int NUM_FLOORS = 11;
  localparam int FLOOR_W    = 4;

  localparam logic [1:0] MOTOR_IDLE = 2'b00;
  localparam logic [1:0] MOTOR_UP   = 2'b11;
  localparam logic [1:0] MOTOR_DOWN = 2'b10;

  typedef enum logic {DOOR_CLOSED, DOOR_OPEN} door_state_t;
endpackage

// File: rtl/lift_btn_debounce.sv
// rtl/lift_btn_debounce.sv - button synchronizer, debouncer and press (rising-edge) detector
module lift_btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic press_o
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d, level_prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Any sample agreeing with the current level restarts the stability count.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= btn_i;
      sync2_q      <= sync1_q;
      level_q      <= level_d;
      level_prev_q <= level_q;
      cnt_q        <= cnt_d;
    end
  end

  assign press_o = level_q & ~level_prev_q;
endmodule

// File: rtl/lift_call_panel.sv
// rtl/lift_call_panel.sv - request register, door FSM and dwell timer in front of the lift controller
module lift_call_panel
  import lift_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DOOR_CYCLES     = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NUM_FLOORS-1:0] btn_hall_i,
  input  logic [NUM_FLOORS-1:0] btn_car_i,
  input  logic [FLOOR_W-1:0]    curr_floor_i,
  input  logic [1:0]            motor_signal_i,
  output logic [NUM_FLOORS-1:0] floor_req_o,
  output logic                  door_open_o,
  output logic                  served_pulse_o,
  output logic [FLOOR_W-1:0]    served_floor_o,
  output logic                  door_fault_o
);
  localparam int DWELL_W = $clog2(DOOR_CYCLES);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DOOR_CYCLES - 1);

  logic [NUM_FLOORS-1:0] hall_press, car_press, press, floor_bit;
  door_state_t           state_q, state_d;
  logic [DWELL_W-1:0]    dwell_q, dwell_d;
  logic [NUM_FLOORS-1:0] req_q, req_d;
  logic                  served_pulse_q, served_pulse_d;
  logic [FLOOR_W-1:0]    served_floor_q, served_floor_d;
  logic                  fault_q, fault_d;

  for (genvar g = 0; g < NUM_FLOORS; g++) begin : g_btn
    lift_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_hall (
      .clk_i(clk_i), .rst_ni(rst_ni), .btn_i(btn_hall_i[g]), .press_o(hall_press[g])
    );
    lift_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_car (
      .clk_i(clk_i), .rst_ni(rst_ni), .btn_i(btn_car_i[g]), .press_o(car_press[g])
    );
  end

  assign press     = hall_press | car_press;
  // Out-of-range floor numbers select nothing, so they never service or reload.
  assign floor_bit = (curr_floor_i < FLOOR_W'(NUM_FLOORS)) ?
                     (NUM_FLOORS'(1) << curr_floor_i) : '0;

  always_comb begin
    state_d        = state_q;
    dwell_d        = dwell_q;
    req_d          = req_q | press;
    served_pulse_d = 1'b0;
    served_floor_d = served_floor_q;
    fault_d        = fault_q;
    case (state_q)
      DOOR_CLOSED: begin
        if (motor_signal_i == MOTOR_IDLE && |(req_q & floor_bit)) begin
          state_d        = DOOR_OPEN;
          dwell_d        = DWELL_LAST;
          req_d          = (req_q | press) & ~floor_bit;
          served_pulse_d = 1'b1;
          served_floor_d = curr_floor_i;
        end
      end
      DOOR_OPEN: begin
        // A press at the open floor only extends the dwell.
        req_d = req_q | (press & ~floor_bit);
        if (motor_signal_i != MOTOR_IDLE) begin
          state_d = DOOR_CLOSED;
          fault_d = 1'b1;
        end else if (|(press & floor_bit)) begin
          dwell_d = DWELL_LAST;
        end else if (dwell_q == '0) begin
          state_d = DOOR_CLOSED;
        end else begin
          dwell_d = dwell_q - 1'b1;
        end
      end
      default: state_d = DOOR_CLOSED;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= DOOR_CLOSED;
      dwell_q        <= '0;
      req_q          <= '0;
      served_pulse_q <= 1'b0;
      served_floor_q <= '0;
      fault_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      dwell_q        <= dwell_d;
      req_q          <= req_d;
      served_pulse_q <= served_pulse_d;
      served_floor_q <= served_floor_d;
      fault_q        <= fault_d;
    end
  end

  assign floor_req_o    = req_q;
  assign door_open_o    = (state_q == DOOR_OPEN);
  assign served_pulse_o = served_pulse_q;
  assign served_floor_o = served_floor_q;
  assign door_fault_o   = fault_q;
endmodule
